// File: rtl/core_reset_sequencer.sv
// Staggered per-core reset release after a wake-up delay, plus per-core soft resets.
// Release latency SYNC_STAGES cycles per channel; no backpressure, request edges are dropped while busy.
module core_reset_sequencer #(
   parameter int N_CORES     = 4,
   parameter int WAKE_CNT_W  = 16,
   parameter int STAGGER     = 8,
   parameter int SOFT_HOLD   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [N_CORES-1:0] core_mask_i,
   input  logic [N_CORES-1:0] soft_rst_req_i,
   output logic [N_CORES-1:0] soft_rst_ack_o,
   output logic [N_CORES-1:0] core_rst_no,
   output logic               all_released_o,
   output logic [1:0]         state_o
);

   localparam int STG_W  = $clog2(STAGGER + 1);
   localparam int HOLD_W = $clog2(SOFT_HOLD + 1);
   localparam logic [STG_W-1:0]      STG_RELOAD = STG_W'(STAGGER - 1);
   localparam logic [HOLD_W-1:0]     HOLD_LOAD  = HOLD_W'(SOFT_HOLD);
   localparam logic [WAKE_CNT_W-1:0] WAKE_LAST  = WAKE_CNT_W'((1 << (WAKE_CNT_W - 1)) - 1);

   typedef enum logic [1:0] {
      ST_WAKE    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   state_t                             state_q;
   state_t                             state_d;
   logic [WAKE_CNT_W-1:0]              wake_cnt_q;
   logic [STG_W-1:0]                   stg_cnt_q;
   logic [N_CORES-1:0]                 mask_q;
   logic [N_CORES-1:0]                 pending_q;
   logic [N_CORES-1:0]                 int_rst_q;
   logic [N_CORES-1:0]                 in_soft_q;
   logic [N_CORES-1:0]                 req_q;
   logic [N_CORES-1:0]                 ack_q;
   logic [N_CORES-1:0][HOLD_W-1:0]     hold_cnt_q;
   logic [N_CORES-1:0][SYNC_STAGES-1:0] pipe_q;
   logic [N_CORES-1:0][SYNC_STAGES-1:0] pipe_nxt;
   logic [N_CORES-1:0]                 release_sel;
   logic [N_CORES-1:0]                 soft_start;
   logic [N_CORES-1:0]                 ack_d;
   logic                               sel_found;
   logic                               wake_done;
   logic                               release_now;

   assign wake_done   = (state_q == ST_WAKE) && (wake_cnt_q == WAKE_LAST);
   assign release_now = (state_q == ST_RELEASE) && (stg_cnt_q == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_WAKE;
      end else begin
         state_q <= state_d;
      end
   end

   // Lowest pending enabled core gets the next release slot; masked cores never enter pending.
   always_comb begin
      state_d     = state_q;
      release_sel = '0;
      sel_found   = 1'b0;
      for (int i = 0; i < N_CORES; i++) begin
         if (pending_q[i] && !sel_found) begin
            release_sel[i] = 1'b1;
            sel_found      = 1'b1;
         end
      end
      case (state_q)
         ST_WAKE: begin
            if (wake_done) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (release_now && ((pending_q & ~release_sel) == '0)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_WAKE;
         end
      endcase
   end

   // Internal reset clears the pipeline directly; a released channel shifts ones toward the output.
   always_comb begin
      pipe_nxt   = '0;
      soft_start = '0;
      ack_d      = '0;
      for (int i = 0; i < N_CORES; i++) begin
         pipe_nxt[i]   = int_rst_q[i] ? '0 : SYNC_STAGES'({pipe_q[i], 1'b1});
         soft_start[i] = (state_q == ST_RUN) && mask_q[i] && pipe_q[i][SYNC_STAGES-1] &&
                         !in_soft_q[i] && soft_rst_req_i[i] && !req_q[i];
         ack_d[i]      = in_soft_q[i] && !pipe_q[i][SYNC_STAGES-1] && pipe_nxt[i][SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wake_cnt_q <= '0;
         stg_cnt_q  <= '0;
         mask_q     <= '0;
         pending_q  <= '0;
         int_rst_q  <= '1;
         in_soft_q  <= '0;
         req_q      <= '0;
         ack_q      <= '0;
         hold_cnt_q <= '0;
         pipe_q     <= '0;
      end else begin
         if (!wake_cnt_q[WAKE_CNT_W-1]) begin
            wake_cnt_q <= wake_cnt_q + 1'b1;
         end
         if (wake_done) begin
            mask_q    <= core_mask_i;
            pending_q <= core_mask_i;
            stg_cnt_q <= '0;
         end else if (release_now) begin
            pending_q <= pending_q & ~release_sel;
            if (sel_found) begin
               stg_cnt_q <= STG_RELOAD;
            end
         end else if (state_q == ST_RELEASE) begin
            stg_cnt_q <= stg_cnt_q - 1'b1;
         end
         req_q  <= soft_rst_req_i;
         ack_q  <= ack_d;
         pipe_q <= pipe_nxt;
         for (int i = 0; i < N_CORES; i++) begin
            if (release_now && release_sel[i]) begin
               int_rst_q[i] <= 1'b0;
            end
            // A soft reset stays flagged until its ack, which blocks new edges while draining.
            if (soft_start[i]) begin
               int_rst_q[i]  <= 1'b1;
               hold_cnt_q[i] <= HOLD_LOAD;
               in_soft_q[i]  <= 1'b1;
            end else if (in_soft_q[i]) begin
               if (ack_d[i]) begin
                  in_soft_q[i] <= 1'b0;
               end
               if (int_rst_q[i]) begin
                  if (hold_cnt_q[i] == '0) begin
                     int_rst_q[i] <= 1'b0;
                  end else begin
                     hold_cnt_q[i] <= hold_cnt_q[i] - 1'b1;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      core_rst_no = '0;
      for (int i = 0; i < N_CORES; i++) begin
         core_rst_no[i] = pipe_q[i][SYNC_STAGES-1];
      end
   end

   assign all_released_o = (state_q == ST_RUN) && (&(core_rst_no | ~mask_q));
   assign soft_rst_ack_o = ack_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_core_reset_sequencer.sv
// Randomized bench for core_reset_sequencer with a timeline-based reference model and scoreboard.
module tb_core_reset_sequencer;

   localparam int N    = 4;
   localparam int WW   = 4;
   localparam int STG  = 3;
   localparam int HOLD = 5;
   localparam int SYNC = 2;
   localparam int C0   = 1 << (WW - 1);

   logic         clk = 1'b0;
   logic         rst_i = 1'b1;
   logic [N-1:0] core_mask_i = '0;
   logic [N-1:0] soft_rst_req_i = '0;
   logic [N-1:0] soft_rst_ack_o;
   logic [N-1:0] core_rst_no;
   logic         all_released_o;
   logic [1:0]   state_o;

   always #5 clk = ~clk;

   core_reset_sequencer #(
      .N_CORES(N), .WAKE_CNT_W(WW), .STAGGER(STG), .SOFT_HOLD(HOLD), .SYNC_STAGES(SYNC)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .core_mask_i(core_mask_i),
      .soft_rst_req_i(soft_rst_req_i),
      .soft_rst_ack_o(soft_rst_ack_o),
      .core_rst_no(core_rst_no),
      .all_released_o(all_released_o),
      .state_o(state_o)
   );

   typedef struct {
      int           cyc;
      logic [N-1:0] rstn;
      logic [N-1:0] ack;
      logic         allrel;
      logic [1:0]   st;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: absolute cycle timeline since the last reset deassertion.
   int           cyc = 0;
   logic [N-1:0] mask_s = '0;
   int           rise [N];
   int           last_rel = 0;
   int           t_sr [N];
   bit           has_t [N];
   logic [N-1:0] prev_req = '0;

   logic         cur_rst = 1'b1;
   logic [N-1:0] cur_mask = '0;
   logic [N-1:0] cur_req = '0;

   function automatic logic [1:0] f_state(input int c);
      if (c < C0) return 2'd0;
      if (c < last_rel) return 2'd1;
      return 2'd2;
   endfunction

   function automatic bit f_busy(input int i, input int c);
      return has_t[i] && (c >= t_sr[i]) && (c <= t_sr[i] + HOLD + SYNC);
   endfunction

   function automatic logic f_rstn(input int i, input int c);
      if (c < C0 || !mask_s[i] || c < rise[i]) return 1'b0;
      if (has_t[i] && c >= t_sr[i] + 1 && c <= t_sr[i] + HOLD + SYNC) return 1'b0;
      return 1'b1;
   endfunction

   task automatic chk(input string nm, input int c, input logic [3:0] got, input logic [3:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%b want=%b", nm, c, got, want);
      end
   endtask

   // Drive one cycle of stimulus, predict the outputs after the coming edge, then advance.
   task automatic step();
      exp_t e;
      int   rank;
      rst_i          = cur_rst;
      core_mask_i    = cur_mask;
      soft_rst_req_i = cur_req;
      if (cur_rst) begin
         cyc      = 0;
         prev_req = '0;
         for (int i = 0; i < N; i++) has_t[i] = 1'b0;
         e.cyc    = 0;
         e.rstn   = '0;
         e.ack    = '0;
         e.allrel = 1'b0;
         e.st     = 2'd0;
      end else begin
         cyc++;
         if (cyc == C0) begin
            mask_s = cur_mask;
            rank   = 0;
            for (int i = 0; i < N; i++) begin
               rise[i] = 0;
               if (cur_mask[i]) begin
                  rise[i] = C0 + 1 + rank * STG + SYNC;
                  rank++;
               end
            end
            last_rel = (rank == 0) ? C0 + 1 : C0 + 1 + (rank - 1) * STG;
         end
         for (int i = 0; i < N; i++) begin
            if (f_state(cyc - 1) == 2'd2 && mask_s[i] && f_rstn(i, cyc - 1) &&
                !f_busy(i, cyc - 1) && cur_req[i] && !prev_req[i]) begin
               t_sr[i]  = cyc;
               has_t[i] = 1'b1;
            end
         end
         prev_req = cur_req;
         e.cyc    = cyc;
         for (int i = 0; i < N; i++) begin
            e.rstn[i] = f_rstn(i, cyc);
            e.ack[i]  = has_t[i] && (cyc == t_sr[i] + HOLD + SYNC + 1);
         end
         e.st     = f_state(cyc);
         e.allrel = (e.st == 2'd2) && ((e.rstn | ~mask_s) == '1);
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      cur_rst = 1'b0;
      repeat (n) step();
   endtask

   task automatic run_reset(input int n);
      cur_rst = 1'b1;
      repeat (n) step();
      cur_rst = 1'b0;
   endtask

   // Monitor: outputs are sampled mid-cycle and compared against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("core_rst_no", e.cyc, core_rst_no, e.rstn);
            chk("soft_rst_ack", e.cyc, soft_rst_ack_o, e.ack);
            chk("all_released", e.cyc, {3'b000, all_released_o}, {3'b000, e.allrel});
            chk("state", e.cyc, {2'b00, state_o}, {2'b00, e.st});
         end
      end
   end

   initial begin
      // Full mask, nominal release timing.
      cur_mask = 4'b1111;
      cur_req  = '0;
      run_reset(3);
      run(25);
      // Single soft reset on core 2.
      cur_req = 4'b0100; run(3);
      cur_req = 4'b0000; run(12);
      // Cores 0 and 3 together, core 3 held past its ack, then re-armed.
      cur_req = 4'b1001; run(2);
      cur_req = 4'b1000; run(19);
      cur_req = 4'b0000; run(2);
      cur_req = 4'b1000; run(12);
      cur_req = 4'b0000; run(3);
      // Sparse mask; requests on a masked core are ignored.
      cur_mask = 4'b1010;
      run_reset(1);
      run(20);
      cur_req = 4'b0001; run(3);
      cur_req = 4'b0000; run(3);
      cur_req = 4'b0010; run(2);
      cur_req = 4'b0000; run(10);
      // Reset pulse in the middle of the release phase.
      cur_mask = 4'b1111;
      run_reset(1);
      run(13);
      run_reset(1);
      run(25);
      // Requests rising during wake-up and held.
      run_reset(1);
      run(3);
      cur_req = 4'b1111; run(30);
      cur_req = 4'b0000;
      // Empty mask goes straight to run.
      cur_mask = 4'b0000;
      run_reset(1);
      run(12);
      // Randomized rounds.
      for (int r = 0; r < 30; r++) begin
         cur_mask = 4'($urandom);
         cur_req  = 4'($urandom);
         run_reset(1 + int'($urandom_range(0, 2)));
         for (int k = 0; k < 80; k++) begin
            for (int b = 0; b < N; b++) begin
               if ($urandom_range(0, 5) == 0) cur_req[b] = ~cur_req[b];
            end
            if ($urandom_range(0, 9) == 0) cur_mask = 4'($urandom);
            cur_rst = ($urandom_range(0, 199) == 0);
            step();
            cur_rst = 1'b0;
         end
      end
      @(negedge clk);
      #1;
      chk("sb_drain", cyc, 4'(exp_q.size()), 4'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
